// File: rtl/serial_add_seq_pkg.sv
// Shared definitions for the add/subtract datapath.
// State encoding and counter-width helper.
package fp_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 0; i < 31; i++) begin
            if (((n - 1) >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_add_seq_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The adder is the slave; the producer/consumer side is the master.
interface serial_add_seq_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

endinterface

// File: rtl/serial_add_seq_fa.sv
// Single-bit full adder cell, time-shared by the serial sequencer.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: one full adder, LSB first,
// one bit per clock, valid/ready on both sides.
module serial_add_seq
    import fp_add_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_add_seq_if.slave bus
);

    localparam int            CW   = clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  s_sr;
    logic          cy;
    logic [CW-1:0] cnt;
    logic          out_valid_r;
    logic          cout_r;
    logic          ovf_r;
    logic          busy_r;
    logic          fa_s;
    logic          fa_co;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (cy),
        .sum  (fa_s),
        .cout (fa_co)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = s_sr;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.busy      = busy_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            s_sr        <= '0;
            cy          <= 1'b0;
            cnt         <= '0;
            out_valid_r <= 1'b0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtract is A + ~B + 1; cin is overridden.
                        a_sr   <= bus.a;
                        b_sr   <= bus.sub ? ~bus.b : bus.b;
                        cy     <= bus.sub | bus.cin;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    s_sr <= {fa_s, s_sr[W-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    cy   <= fa_co;
                    if (cnt == LAST) begin
                        // cy still holds the carry into the MSB here.
                        ovf_r       <= cy ^ fa_co;
                        cout_r      <= fa_co;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial integer add/subtract sequencer that time-shares one `full_adder` cell across a W-bit operand pair, LSB first, one bit per clock. It sits beside the floating-point adder datapath as a low-area alternative for mantissa/exponent arithmetic. It accepts operands via a valid/ready handshake, runs W bit-cycles, then presents sum, carry-out and signed overflow until the consumer takes them.

## Interface
- `W`, 32, operand width; legal range 2..64.
- `clk` input 1, single clock, rising edge.
- `rst_n` input 1, reset, asynchronous, active-low.
- `in_valid` input 1, operands valid.
- `in_ready` output 1, block can accept operands.
- `a` input W, operand A.
- `b` input W, operand B.
- `cin` input 1, carry-in for add; ignored when `sub`=1.
- `sub` input 1, 1 = compute A−B (B inverted, carry-in forced 1).
- `out_valid` output 1, result valid.
- `out_ready` input 1, consumer takes result.
- `sum` output W, result.
- `cout` output 1, carry out of MSB; for subtract 1 = no borrow.
- `ovf` output 1, two's-complement overflow.
- `busy` output 1, high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready` at an edge: load A shift reg ← `a`, B shift reg ← (`sub` ? ~`b` : `b`), carry reg ← (`sub` ? 1 : `cin`), bit counter ← 0, go RUN.
- RUN: `full_adder` inputs = A[0], B[0], carry reg. Each edge: sum shift reg shifts right with cell Sum entering at bit W−1; A and B shift right; carry reg ← cell Cout; counter +1. On the edge processing bit W−1 (counter = W−1): capture carry-in-to-MSB (carry reg before update) for `ovf`, latch `cout` ← cell Cout, go DONE.
- DONE: `out_valid`=1; `sum`, `cout`, `ovf` stable. On `out_valid`&&`out_ready`: go IDLE.
- `ovf` = carry into MSB XOR carry out of MSB.
- `in_ready` = (state==IDLE), combinational from the state register. `in_valid` outside IDLE is ignored and captures nothing.
- `sum`/`cout`/`ovf` are meaningful only while `out_valid`=1. In RUN, `sum` shows partial shift contents.
- Counter width is clog2(W). No wrap beyond W−1; the counter is reloaded on acceptance.

## Timing
- Reset (async assert, any state): state IDLE, `out_valid`=0, `busy`=0, `sum`=0, `cout`=0, `ovf`=0, all internal regs 0. `in_ready`=1, including while reset is held.
- Reset mid-RUN or mid-DONE aborts the operation; no result is ever presented for it.
- Latency: acceptance edge E0 → `out_valid` high in the cycle after edge E0+W (W edges of RUN).
- Minimum issue interval is W+2 cycles: no acceptance in DONE, even with `out_ready`=1 in the same cycle.
- `out_ready` held low keeps DONE indefinitely with outputs frozen.

## Structure
- Shared package `fp_add_pkg`: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the clog2 helper for counter width.
- One sub-module: instance `u_fa` of the existing `full_adder` cell. All sequencing, shift registers and flags live in `serial_add_seq`.

## Test plan
- Add, W=32, a=0x00000001, b=0x00000001, cin=0 → `sum`=0x00000002, `cout`=0, `ovf`=0; `out_valid` rises exactly 32 edges after acceptance.
- Add, a=0xFFFFFFFF, b=0x00000001, cin=0 → `sum`=0x00000000, `cout`=1, `ovf`=0. Add, a=0x7FFFFFFF, b=0x00000001 → `sum`=0x80000000, `cout`=0, `ovf`=1.
- Subtract, a=5, b=7 → `sum`=0xFFFFFFFE, `cout`=0, `ovf`=0. Subtract, a=0x80000000, b=1 → `sum`=0x7FFFFFFF, `cout`=1, `ovf`=1. `cin`=1 in both cases has no effect.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` → outputs stable, `in_ready`=0. `in_valid` pulsed with new operands during RUN and DONE → ignored, result unchanged. Next operation accepted only after return to IDLE.
- Reset mid-operation: `rst_n` low after bit 13 of RUN → `out_valid`=0, `sum`=0, `busy`=0 immediately. After release, a=3, b=4 add → `sum`=7.
- W=2 instance: a=2'b01, b=2'b01 → `sum`=2'b10, `cout`=0, `ovf`=1; latency 2 edges.
